// File: rtl/ula_pkg.sv
// Shared definitions for the sequential arithmetic unit: op codes and FSM state encoding.
package ula_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } state_e;

endpackage

// File: rtl/ula_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first, WIDTH steps after start.
// done flags the final step; quotient is the value that lands in the register on that step.
module ula_div_iter
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    // Shift the next dividend bit into the partial remainder; a borrow means "restore".
    trial = {rem_q, quo_q[WIDTH-1]};
    diff  = trial - {1'b0, dvs_q};
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      if (!diff[WIDTH]) begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign done     = (cnt_q == CNT_W'(1));
  assign quotient = quo_d;

endmodule

// File: rtl/ula_seq.sv
// Sequential arithmetic unit: 1-cycle add/sub/mul, iterative divide, registered result with backpressure.
// Optional macro ULA_SAT_EN clamps overflowing add/mul to all ones and sub to zero.
module ula_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             div_zero
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic             start_div;
  logic             div_done;
  logic [WIDTH-1:0] quotient;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     dif;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic               alu_dz;

  // rst_n gates in_ready so nothing is offered as accepted while reset is held.
  assign in_ready  = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign start_div = accept && (op == OP_DIV) && (b != '0);

  ula_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_div),
    .dividend (a),
    .divisor  (b),
    .done     (div_done),
    .quotient (quotient)
  );

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    dif     = {1'b0, a} - {1'b0, b};
    prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_dz  = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_ovf = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res = dif[WIDTH-1:0];
        alu_ovf = dif[WIDTH];
      end
      OP_MUL: begin
        alu_res = prod[WIDTH-1:0];
        alu_ovf = |prod[2*WIDTH-1:WIDTH];
      end
      default: begin
        // Only reached for divide-by-zero; a real divide takes the quotient path.
        alu_res = '1;
        alu_dz  = 1'b1;
      end
    endcase
`ifdef ULA_SAT_EN
    if (alu_ovf) begin
      alu_res = (op == OP_SUB) ? '0 : '1;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (start_div) begin
          state_d = ST_DIV;
        end else if (accept) begin
          out_valid_d = 1'b1;
          result_d    = alu_res;
          ovf_d       = alu_ovf;
          dz_d        = alu_dz;
        end
      end
      ST_DIV: begin
        // The output slot was freed when the divide was accepted, so it can load directly.
        if (div_done) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          result_d    = quotient;
          ovf_d       = 1'b0;
          dz_d        = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq (WIDTH=8); expectations follow ULA_SAT_EN when it is defined.
module tb_ula_seq;

`ifdef ULA_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [7:0] E_ADD = SAT ? 8'd255 : 8'd44;
  localparam logic [7:0] E_SUB = SAT ? 8'd0   : 8'd252;
  localparam logic [7:0] E_MUL = SAT ? 8'd255 : 8'd0;
  localparam logic [7:0] E_B2B = SAT ? 8'd255 : 8'd4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       overflow;
  logic       div_zero;

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] exp_q[$];

  ula_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  // Absolute backstop so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    int s;
    logic [7:0] r;
    logic v;
    logic z;
    r = 8'd0;
    v = 1'b0;
    z = 1'b0;
    case (o)
      2'b00: begin s = int'(x) + int'(y); v = (s > 255); r = (SAT && v) ? 8'd255 : 8'(s); end
      2'b01: begin s = int'(x) - int'(y); v = (x < y);   r = (SAT && v) ? 8'd0 : 8'(s); end
      2'b10: begin s = int'(x) * int'(y); v = (s > 255); r = (SAT && v) ? 8'd255 : 8'(s); end
      default: begin
        if (y == 8'd0) begin r = 8'd255; z = 1'b1; end
        else r = 8'(int'(x) / int'(y));
      end
    endcase
    return {z, v, r};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 8'd0; b = 8'd0; op = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_out_valid got %b want 0", out_valid); end
    vectors++; if (result !== 8'd0) begin miscompares++; $display("[TB] FAIL rst_result got %0d want 0", result); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_overflow got %b want 0", overflow); end
    vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_div_zero got %b want 0", div_zero); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_in_ready got %b want 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL post_rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add;
    out_ready = 1'b1; in_valid = 1'b1; op = 2'b00; a = 8'd200; b = 8'd100;
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL add_valid got %b want 1", out_valid); end
    vectors++; if (result !== E_ADD) begin miscompares++; $display("[TB] FAIL add_result got %0d want %0d", result, E_ADD); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL add_overflow got %b want 1", overflow); end
    vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("[TB] FAIL add_div_zero got %b want 0", div_zero); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_valid got %b want 0", out_valid); end
  endtask

  task automatic test_sub_mul;
    logic [1:0] vo [3] = '{2'b01, 2'b10, 2'b10};
    logic [7:0] va [3] = '{8'd5, 8'd16, 8'd15};
    logic [7:0] vb [3] = '{8'd9, 8'd16, 8'd17};
    logic [7:0] er [3] = '{E_SUB, E_MUL, 8'd255};
    logic       ev [3] = '{1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; op = vo[i]; a = va[i]; b = vb[i];
      tick();
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL submul%0d_valid got %b want 1", i, out_valid); end
      vectors++; if (result !== er[i]) begin miscompares++; $display("[TB] FAIL submul%0d_result got %0d want %0d", i, result, er[i]); end
      vectors++; if (overflow !== ev[i]) begin miscompares++; $display("[TB] FAIL submul%0d_overflow got %b want %b", i, overflow, ev[i]); end
      vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("[TB] FAIL submul%0d_div_zero got %b want 0", i, div_zero); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_div;
    int busy;
    busy = 0;
    out_ready = 1'b1; in_valid = 1'b1; op = 2'b11; a = 8'd200; b = 8'd7;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (in_ready === 1'b0 && out_valid === 1'b0) busy++;
      tick();
    end
    vectors++; if (busy != 8) begin miscompares++; $display("[TB] FAIL div_busy_cycles got %0d want 8", busy); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL div_valid_at_9 got %b want 1", out_valid); end
    vectors++; if (result !== 8'd28) begin miscompares++; $display("[TB] FAIL div_result got %0d want 28", result); end
    vectors++; if (overflow !== 1'b0 || div_zero !== 1'b0) begin miscompares++; $display("[TB] FAIL div_flags got %b%b want 00", overflow, div_zero); end
    in_valid = 1'b1; op = 2'b11; a = 8'd5; b = 8'd0;
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL div0_valid got %b want 1", out_valid); end
    vectors++; if (result !== 8'd255) begin miscompares++; $display("[TB] FAIL div0_result got %0d want 255", result); end
    vectors++; if (div_zero !== 1'b1) begin miscompares++; $display("[TB] FAIL div0_flag got %b want 1", div_zero); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL div0_overflow got %b want 0", overflow); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    out_ready = 1'b0; in_valid = 1'b1; op = 2'b00; a = 8'd10; b = 8'd20;
    tick();
    a = 8'd1; b = 8'd1;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp%0d_in_ready got %b want 0", i, in_ready); end
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp%0d_valid got %b want 1", i, out_valid); end
      vectors++; if (result !== 8'd30 || overflow !== 1'b0 || div_zero !== 1'b0) begin
        miscompares++; $display("[TB] FAIL bp%0d_hold got %0d/%b/%b want 30/0/0", i, result, overflow, div_zero);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] va [4] = '{8'd1, 8'd100, 8'd250, 8'd7};
    logic [7:0] vb [4] = '{8'd2, 8'd155, 8'd10, 8'd8};
    logic [7:0] er [4] = '{8'd3, 8'd255, E_B2B, 8'd15};
    logic       ev [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; op = 2'b00; a = va[i]; b = vb[i];
      tick();
      vectors++; if (out_valid !== 1'b1 || result !== er[i] || overflow !== ev[i]) begin
        miscompares++; $display("[TB] FAIL b2b%0d got v%b %0d/%b want v1 %0d/%b", i, out_valid, result, overflow, er[i], ev[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_div;
    int extra;
    extra = 0;
    out_ready = 1'b1; in_valid = 1'b1; op = 2'b00; a = 8'd3; b = 8'd4;
    tick();
    op = 2'b11; a = 8'd200; b = 8'd7;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL middiv_rst_valid got %b want 0", out_valid); end
    vectors++; if (result !== 8'd0) begin miscompares++; $display("[TB] FAIL middiv_rst_result got %0d want 0", result); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL middiv_rst_in_ready got %b want 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL middiv_release_in_ready got %b want 1", in_ready); end
    in_valid = 1'b1; op = 2'b00; a = 8'd1; b = 8'd1;
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || result !== 8'd2 || overflow !== 1'b0 || div_zero !== 1'b0) begin
      miscompares++; $display("[TB] FAIL middiv_add got v%b %0d/%b/%b want v1 2/0/0", out_valid, result, overflow, div_zero);
    end
    repeat (12) begin
      tick();
      if (out_valid !== 1'b0) extra++;
    end
    vectors++; if (extra != 0) begin miscompares++; $display("[TB] FAIL middiv_residue got %0d stray cycles want 0", extra); end
  endtask

  task automatic test_random;
    logic [9:0] got;
    logic [9:0] exp;
    for (int cyc = 0; cyc < 340; cyc++) begin
      if (cyc < 300) begin
        in_valid = 1'($urandom_range(0, 1));
        op       = 2'($urandom_range(0, 3));
        a        = 8'($urandom_range(0, 255));
        b        = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        got = {div_zero, overflow, result};
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("[TB] FAIL rand_dup cyc %0d got %h want none", cyc, got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin miscompares++; $display("[TB] FAIL rand_result cyc %0d got %h want %h", cyc, got, exp); end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(op, a, b));
      @(posedge clk);
      #1;
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("[TB] FAIL rand_lost got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_mul();
    test_div();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_div();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
